// File: rtl/pipe_stage_reg.sv
// Registered pipeline stage with in-order handshake, flush on Req and a saturating stall counter.
// Define PIPE_STAGE_SKID_EN for a head+skid stage with registered in_ready; default is a single entry.
module pipe_stage_reg #(
  parameter int          DATA_W   = 128,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Req,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc,
  input  logic [4:0]        in_exc,
  input  logic              in_bd,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [4:0]        out_exc,
  output logic              out_bd,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ,
  output logic [15:0]       stall_cnt
);

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // Only reset clears the counter; a flush leaves the stall history intact.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

`ifdef PIPE_STAGE_SKID_EN

  logic              skid_full;
  logic [31:0]       skid_pc;
  logic [4:0]        skid_exc;
  logic              skid_bd;
  logic [DATA_W-1:0] skid_data;

  assign occ = {1'b0, out_valid} + {1'b0, skid_full};

  // in_ready is kept as a flop mirroring !skid_full so out_ready never reaches it combinationally.
  always_ff @(posedge clk) begin
    if (reset || Req) begin
      out_valid <= 1'b0;
      out_pc    <= RESET_PC;
      out_exc   <= '0;
      out_bd    <= 1'b0;
      out_data  <= '0;
      skid_full <= 1'b0;
      skid_pc   <= '0;
      skid_exc  <= '0;
      skid_bd   <= 1'b0;
      skid_data <= '0;
      in_ready  <= 1'b1;
    end else if (out_xfer) begin
      if (skid_full) begin
        out_pc    <= skid_pc;
        out_exc   <= skid_exc;
        out_bd    <= skid_bd;
        out_data  <= skid_data;
        skid_full <= 1'b0;
        in_ready  <= 1'b1;
      end else if (in_xfer) begin
        out_pc   <= in_pc;
        out_exc  <= in_exc;
        out_bd   <= in_bd;
        out_data <= in_data;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (in_xfer) begin
      if (!out_valid) begin
        out_valid <= 1'b1;
        out_pc    <= in_pc;
        out_exc   <= in_exc;
        out_bd    <= in_bd;
        out_data  <= in_data;
      end else begin
        skid_full <= 1'b1;
        skid_pc   <= in_pc;
        skid_exc  <= in_exc;
        skid_bd   <= in_bd;
        skid_data <= in_data;
        in_ready  <= 1'b0;
      end
    end
  end

`else

  assign in_ready = !out_valid || out_ready;
  assign occ      = {1'b0, out_valid};

  // Single entry: a new word replaces the head whenever it is empty or draining.
  always_ff @(posedge clk) begin
    if (reset || Req) begin
      out_valid <= 1'b0;
      out_pc    <= RESET_PC;
      out_exc   <= '0;
      out_bd    <= 1'b0;
      out_data  <= '0;
    end else if (in_xfer) begin
      out_valid <= 1'b1;
      out_pc    <= in_pc;
      out_exc   <= in_exc;
      out_bd    <= in_bd;
      out_data  <= in_data;
    end else if (out_xfer) begin
      out_valid <= 1'b0;
    end
  end

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: queue-based reference model compared every cycle,
// plus directed literal checks. Works with or without PIPE_STAGE_SKID_EN defined.
module tb_pipe_stage_reg;

  localparam int          DW  = 8;
  localparam logic [31:0] RPC = 32'h0000_3000;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP  = 2;
  localparam bit SKID = 1'b1;
`else
  localparam int CAP  = 1;
  localparam bit SKID = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          Req;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_pc;
  logic [4:0]    in_exc;
  logic          in_bd;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_pc;
  logic [4:0]    out_exc;
  logic          out_bd;
  logic [DW-1:0] out_data;
  logic [1:0]    occ;
  logic [15:0]   stall_cnt;

  pipe_stage_reg #(.DATA_W(DW), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .Req(Req),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_exc(in_exc), .in_bd(in_bd), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_exc(out_exc), .out_bd(out_bd), .out_data(out_data),
    .occ(occ), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]   pc;
    logic [4:0]    exc;
    logic          bd;
    logic [DW-1:0] data;
  } entry_t;

  entry_t      q[$];
  entry_t      last;
  int unsigned mstall;
  int          compared;
  int          mismatched;

  function automatic entry_t bubble();
    entry_t e;
    e.pc   = RPC;
    e.exc  = '0;
    e.bd   = 1'b0;
    e.data = '0;
    return e;
  endfunction

  function automatic logic model_in_ready();
    if (SKID) return q.size() < CAP;
    return (q.size() == 0) || out_ready;
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic rq, input logic iv,
                               input logic [31:0] pc, input logic [4:0] exc,
                               input logic bd, input logic [DW-1:0] data, input logic ordy);
    reset     = r;
    Req       = rq;
    in_valid  = iv;
    in_pc     = pc;
    in_exc    = exc;
    in_bd     = bd;
    in_data   = data;
    out_ready = ordy;
  endtask

  // Every cycle: outputs vs. model (head of queue, or held last value when empty).
  task automatic checkOutput();
    entry_t h;
    h = (q.size() != 0) ? q[0] : last;
    cmp("out_valid", out_valid, q.size() != 0);
    cmp("out_pc",    out_pc,    h.pc);
    cmp("out_exc",   out_exc,   h.exc);
    cmp("out_bd",    out_bd,    h.bd);
    cmp("out_data",  out_data,  h.data);
    cmp("occ",       occ,       q.size());
    cmp("stall_cnt", stall_cnt, mstall);
    cmp("in_ready",  in_ready,  model_in_ready());
  endtask

  task automatic modelStep();
    entry_t e;
    logic   ir;
    if (reset) begin
      q.delete();
      last   = bubble();
      mstall = 0;
    end else begin
      if (q.size() != 0 && !out_ready && mstall != 32'hFFFF) mstall++;
      if (Req) begin
        q.delete();
        last = bubble();
      end else begin
        ir = model_in_ready();
        if (q.size() != 0 && out_ready) void'(q.pop_front());
        if (in_valid && ir) begin
          e.pc   = in_pc;
          e.exc  = in_exc;
          e.bd   = in_bd;
          e.data = in_data;
          q.push_back(e);
        end
      end
      if (q.size() != 0) last = q[0];
    end
  endtask

  task automatic step(input bit check);
    #1;
    if (check) checkOutput();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, '0, 1'b0);
    step(1'b0);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    mstall     = 0;
    last       = bubble();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, '0, 1'b0);
    @(posedge clk);
    #1;
    doReset();

    // Reset then idle
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, '0, 1'b0);
    #1;
    cmp("rst_out_valid", out_valid, 1'b0);
    cmp("rst_out_pc",    out_pc,    32'h3000);
    cmp("rst_out_data",  out_data,  8'h00);
    cmp("rst_stall",     stall_cnt, 16'd0);
    cmp("rst_occ",       occ,       2'd0);
    cmp("rst_in_ready",  in_ready,  1'b1);
    step(1'b1);

    // Streaming with out_ready=1
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h3000 + 32'(4 * i), 5'd0, 1'b0, 8'(i), 1'b1);
      step(1'b1);
      cmp("stream_pc",    out_pc,    32'h3000 + 32'(4 * i));
      cmp("stream_occ",   occ,       2'd1);
      cmp("stream_valid", out_valid, 1'b1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, '0, 1'b1);
    step(1'b1);

    // Back-pressure
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h3000, 5'd0, 1'b0, 8'h11, 1'b0);
    step(1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h3004, 5'd0, 1'b0, 8'h22, 1'b0);
    step(1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, '0, 1'b0);
    step(1'b1);
    step(1'b1);
    #1;
    cmp("bp_stall",    stall_cnt, 16'd3);
    cmp("bp_occ",      occ,       SKID ? 2'd2 : 2'd1);
    cmp("bp_in_ready", in_ready,  1'b0);
    cmp("bp_head",     out_pc,    32'h3000);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, '0, 1'b1);
    step(1'b1);
    cmp("bp_second",   out_pc,    SKID ? 32'h3004 : 32'h3000);
    cmp("bp_valid2",   out_valid, SKID);
    step(1'b1);

    // Flush with a coinciding input that must be dropped
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h3000, 5'd1, 1'b1, 8'h33, 1'b0);
    step(1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h3004, 5'd2, 1'b0, 8'h44, 1'b0);
    step(1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h3010, 5'd3, 1'b1, 8'h55, 1'b1);
    step(1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, '0, 1'b0);
    #1;
    cmp("fl_occ",      occ,       2'd0);
    cmp("fl_valid",    out_valid, 1'b0);
    cmp("fl_pc",       out_pc,    32'h3000);
    cmp("fl_exc",      out_exc,   5'd0);
    cmp("fl_stall",    stall_cnt, 16'd4);
    cmp("fl_in_ready", in_ready,  1'b1);
    step(1'b1);
    cmp("fl_no_emit",  out_valid, 1'b0);

    // Payload pass-through
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h3020, 5'd4, 1'b1, 8'hA5, 1'b1);
    step(1'b1);
    cmp("pt_exc",  out_exc,  5'd4);
    cmp("pt_bd",   out_bd,   1'b1);
    cmp("pt_data", out_data, 8'hA5);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      applyStimulus(($urandom_range(0, 63) == 0), ($urandom_range(0, 31) == 0),
                    ($urandom_range(0, 9) < 7), $urandom, 5'($urandom), 1'($urandom),
                    DW'($urandom), ($urandom_range(0, 9) < 6));
      step(1'b1);
    end

    // Stall counter saturation
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h3040, 5'd0, 1'b0, 8'h66, 1'b0);
    step(1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 70000; i++) step(1'b1);
    cmp("sat_stall", stall_cnt, 16'hFFFF);
    doReset();
    cmp("sat_reset", stall_cnt, 16'd0);
    cmp("sat_occ",   occ,       2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
- REQ-001 The module SHALL have parameter DATA_W, default 128, giving the payload width in bits; legal range 1..1024.
- REQ-002 The module SHALL have parameter RESET_PC, default 32'h0000_3000, giving the PC value of a bubble.
- REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
- REQ-004 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
- REQ-005 The module SHALL have port Req, input, 1 bit: flush request on exception/interrupt entry.
- REQ-006 The module SHALL have ports in_valid (input, 1) and in_ready (output, 1): the upstream handshake.
- REQ-007 The module SHALL have ports in_pc (input, 32), in_exc (input, 5), in_bd (input, 1) and in_data (input, DATA_W): the incoming payload.
- REQ-008 The module SHALL have ports out_valid (output, 1) and out_ready (input, 1): the downstream handshake.
- REQ-009 The module SHALL have ports out_pc (output, 32), out_exc (output, 5), out_bd (output, 1) and out_data (output, DATA_W): the head payload.
- REQ-010 The module SHALL have port occ, output, 2 bits: number of held entries (0..2).
- REQ-011 The module SHALL have port stall_cnt, output, 16 bits: count of back-pressured cycles.

Function
- REQ-012 An input transfer SHALL occur when in_valid && in_ready at a rising edge; an output transfer SHALL occur when out_valid && out_ready at a rising edge.
- REQ-013 Entries SHALL be delivered strictly in acceptance order, with no loss and no duplication.
- REQ-014 Latency SHALL be one cycle: a word accepted at edge N appears on out_* after edge N if the stage was empty, or after the head drains otherwise.
- REQ-015 The out_* payload SHALL come directly from flops, with no combinational path from in_* to out_*.
- REQ-016 When the head is consumed and nothing replaces it, out_valid SHALL fall to 0 and the payload SHALL hold its last value.
- REQ-017 A simultaneous output transfer and input transfer on a one-entry stage SHALL replace the head; occ stays 1 and out_valid stays 1.
- REQ-018 Req SHALL take priority over everything, including reset-free state updates: at the next edge both entries are emptied, out_valid=0, occ=0, and the payload becomes the bubble (pc=RESET_PC, exc=0, bd=0, data=0).
- REQ-019 Any input transfer coinciding with Req SHALL be discarded.
- REQ-020 in_ready SHALL equal 1 in the cycle after a flush.
- REQ-021 stall_cnt SHALL increment by one on each cycle with out_valid && !out_ready, and SHALL saturate at 16'hFFFF.
- REQ-022 stall_cnt SHALL be unaffected by Req.
- REQ-023 in_exc, in_bd and in_pc SHALL be carried unmodified; the block never generates exception codes.

Reset
- REQ-024 On reset, the next edge SHALL set out_valid=0, occ=0, stall_cnt=0, out_pc=RESET_PC, out_exc=0, out_bd=0, out_data=0, and clear the skid entry.
- REQ-025 Reset SHALL take precedence over Req and over all transfers.
- REQ-026 Reset asserted mid-stall SHALL discard held entries without emitting them.

Configuration
- REQ-027 Macro PIPE_STAGE_SKID_EN SHALL select the buffering structure.
- REQ-028 With PIPE_STAGE_SKID_EN defined, the stage SHALL hold a head entry plus one skid entry.
- REQ-029 With PIPE_STAGE_SKID_EN defined, in_ready SHALL be a flop output equal to !skid_full, with no combinational path from out_ready to in_ready.
- REQ-030 With PIPE_STAGE_SKID_EN defined, a word accepted while the head is full and not draining SHALL enter the skid entry (occ=2).
- REQ-031 With PIPE_STAGE_SKID_EN defined, when the head drains the skid entry SHALL move to the head on the same edge.
- REQ-032 Without PIPE_STAGE_SKID_EN, the stage SHALL hold a single entry and in_ready = !out_valid || out_ready, combinationally.
- REQ-033 Without PIPE_STAGE_SKID_EN, occ SHALL never exceed 1.

Verification
- REQ-034 Reset then idle: after the reset edge, out_valid=0, out_pc=32'h3000, out_data=0, stall_cnt=0, occ=0, in_ready=1.
- REQ-035 Streaming: in_pc=0x3000,0x3004,0x3008 on consecutive cycles with out_ready=1 -> the same PCs appear one cycle later, back-to-back, with occ=1 throughout.
- REQ-036 Back-pressure (skid build): out_ready=0 for 3 cycles while offering 0x3000 and 0x3004 -> occ=2, in_ready=0, stall_cnt=3; on out_ready=1, 0x3000 then 0x3004 emerge in order.
- REQ-037 Flush: Req=1 with occ=2 and in_valid=1 (pc=0x3010) -> next cycle occ=0, out_valid=0, out_pc=0x3000, out_exc=0; 0x3010 is never emitted; stall_cnt keeps its value.
- REQ-038 Payload pass-through: in_exc=5'd4, in_bd=1, DATA_W=8 with in_data=8'hA5 -> out_exc=4, out_bd=1, out_data=8'hA5.
- REQ-039 Saturation: hold out_valid=1 with out_ready=0 for 70000 cycles -> stall_cnt=16'hFFFF; reset -> 0.
